fwd_hazard_unit: RTL

- Parametrised forwarding and hazard unit for the in-order integer pipeline.
- Tracks in-flight destination registers per pipeline stage.
- Generates forwarding selects for NUM_SRC operands of the instruction in EX, from any later stage.
- Generates the load-use stall for the instruction in ID.
- Sits beside the ID/EX boundary. Drives the EX operand muxes and the IF/ID hold/bubble controls.

---
 rtl/fwd_hazard_pkg.sv | 37 +++
 rtl/fwd_hazard_unit_match.sv | 31 +++
 rtl/fwd_hazard_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/fwd_hazard_pkg.sv
// Shared types and defaults for the forwarding / load-use hazard unit.
// One pipeline-stage tracking entry is described here so both the top and the matcher agree on it.
package fwd_hazard_pkg;

    localparam int DEF_DEPTH      = 3;
    localparam int DEF_NUM_SRC    = 2;
    localparam int DEF_REG_AW     = 5;
    localparam int DEF_LOAD_READY = 2;
    localparam int DEF_CNT_W      = 16;

    localparam int FWD_RF = 0;

    // Entry fields are sized for the widest legal configuration; narrower
    // register addresses are zero-extended into rd.
    localparam int MAX_REG_AW = 8;
    localparam int RDY_W      = 4;

    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] rd;
        logic                  regwrite;
        logic [RDY_W-1:0]      rdy;
    } stage_entry_t;

    localparam stage_entry_t BUBBLE = '{
        valid:    1'b0,
        rd:       {MAX_REG_AW{1'b0}},
        regwrite: 1'b0,
        rdy:      RDY_W'(1)
    };

    // x0 is hard-wired, so a producer targeting it never forwards or stalls.
    function automatic logic entry_writes(input stage_entry_t e);
        return e.valid && e.regwrite && (e.rd != {MAX_REG_AW{1'b0}});
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// Youngest-match finder: compares one register address against the masked
// stage entries and reports the lowest matching stage, its hit flag and its ready stage.
module fwd_match_prio
    import fwd_hazard_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = $clog2(DEF_DEPTH)
) (
    input  logic [MAX_REG_AW-1:0]        addr,
    input  stage_entry_t [DEPTH-1:0]     entries,
    input  logic [DEPTH-1:0]             mask,
    output logic                         hit,
    output logic [IDX_W-1:0]             idx,
    output logic [RDY_W-1:0]             rdy
);

    // Scan oldest to youngest so the lowest matching index wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        rdy = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (mask[i] && entry_writes(entries[i]) && (entries[i].rd == addr)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
                rdy = entries[i].rdy;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation for the in-order integer pipeline,
// tracking destination registers of instructions from EX onward.
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int REG_AW     = DEF_REG_AW,
    parameter int LOAD_READY = DEF_LOAD_READY,
    parameter int CNT_W      = DEF_CNT_W,
    localparam int SEL_W     = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      advance,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_is_load,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_count
);

    // The ID stall check looks at entries 0..DEPTH-2, EX forwarding at 1..DEPTH-1.
    localparam logic [DEPTH-1:0] STALL_MASK = {1'b0, {(DEPTH-1){1'b1}}};
    localparam logic [DEPTH-1:0] FWD_MASK   = {{(DEPTH-1){1'b1}}, 1'b0};

    stage_entry_t [DEPTH-1:0]    entry_reg;
    logic [NUM_SRC*REG_AW-1:0]   ex_rs_reg;
    logic [CNT_W-1:0]            stall_count_reg;

    stage_entry_t                id_entry;
    logic [NUM_SRC-1:0]          src_stall;

    always_comb begin
        id_entry          = BUBBLE;
        id_entry.valid    = id_valid;
        id_entry.rd       = MAX_REG_AW'(id_rd);
        id_entry.regwrite = id_regwrite;
        id_entry.rdy      = id_is_load ? RDY_W'(LOAD_READY) : RDY_W'(1);
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic                 hit_id;
        logic [SEL_W-1:0]     idx_id;
        logic [RDY_W-1:0]     rdy_id;
        logic                 hit_ex;
        logic [SEL_W-1:0]     idx_ex;
        logic [RDY_W-1:0]     unused_rdy_ex;

        fwd_match_prio #(
            .DEPTH (DEPTH),
            .IDX_W (SEL_W)
        ) u_id_match (
            .addr    (MAX_REG_AW'(id_rs[gi*REG_AW +: REG_AW])),
            .entries (entry_reg),
            .mask    (STALL_MASK),
            .hit     (hit_id),
            .idx     (idx_id),
            .rdy     (rdy_id)
        );

        fwd_match_prio #(
            .DEPTH (DEPTH),
            .IDX_W (SEL_W)
        ) u_ex_match (
            .addr    (MAX_REG_AW'(ex_rs_reg[gi*REG_AW +: REG_AW])),
            .entries (entry_reg),
            .mask    (FWD_MASK),
            .hit     (hit_ex),
            .idx     (idx_ex),
            .rdy     (unused_rdy_ex)
        );

        // When the consumer reaches EX the producer sits one stage further on.
        assign src_stall[gi] = hit_id && ((int'(idx_id) + 1) < int'(rdy_id));

        assign fwd_sel[gi*SEL_W +: SEL_W] = (entry_reg[0].valid && hit_ex) ? idx_ex
                                                                           : SEL_W'(FWD_RF);
    end

    // A flushed ID instruction is dead, so it cannot cause a hazard.
    assign stall       = id_valid && !flush && (|src_stall);
    assign stall_count = stall_count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= BUBBLE;
            end
            ex_rs_reg       <= '0;
            stall_count_reg <= '0;
        end else if (advance) begin
            for (int i = 1; i < DEPTH; i++) begin
                entry_reg[i] <= entry_reg[i-1];
            end
            if (flush) begin
                entry_reg[0] <= BUBBLE;
                entry_reg[1] <= BUBBLE;
            end else if (stall) begin
                entry_reg[0] <= BUBBLE;
            end else begin
                entry_reg[0] <= id_entry;
                ex_rs_reg    <= id_rs;
            end
            if (stall && (stall_count_reg != {CNT_W{1'b1}})) begin
                stall_count_reg <= stall_count_reg + CNT_W'(1);
            end
        end else if (flush) begin
            entry_reg[0] <= BUBBLE;
        end
    end

endmodule
